// File: rtl/cr_xp10_decomp_be_err_stat_pkg.sv
// Shared types for the decompressor back-end error/status block:
// status record layout and the intake FSM encoding.
package cr_xp10_decompPKG;

    localparam int unsigned BE_ERR_TAG_W = 8;

    typedef struct packed {
        logic [BE_ERR_TAG_W-1:0] tag;
        logic                    size_err;
        logic                    crc_err;
    } be_err_stat_t;

    typedef enum logic {
        BE_ERR_RUN  = 1'b0,
        BE_ERR_HALT = 1'b1
    } be_err_state_e;

endpackage

// File: rtl/cr_xp10_decomp_be_err_stat_fifo.sv
// nx_fifo: registered-storage synchronous FIFO, no fall-through.
// Push is ignored when full and pop is ignored when empty.
module nx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        wr_d    = wr_q + {{AW{1'b0}}, push_ok};
        rd_d    = rd_q + {{AW{1'b0}}, pop_ok};
        rdata   = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cr_xp10_decomp_be_err_stat.sv
// Back-end error/status collector: queues per-frame check results, keeps
// saturating statistics, irq, and optional halt-on-error. Trace outputs
// are enabled by CR_XP10_DECOMP_BE_ERR_TRACE_EN.
module cr_xp10_decomp_be_err_stat
    import cr_xp10_decompPKG::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_done,
    input  logic [TAG_W-1:0] chk_tag,
    input  logic             size_error,
    input  logic             crc_error,
    output logic             chk_ready,
    input  logic             stop_on_err,
    input  logic             resume,
    input  logic             clr_cnt,
    input  logic             irq_clr,
    output logic             stat_valid,
    input  logic             stat_ready,
    output logic [TAG_W-1:0] stat_tag,
    output logic             stat_size_err,
    output logic             stat_crc_err,
    output logic [CNT_W-1:0] frm_cnt,
    output logic [CNT_W-1:0] size_err_cnt,
    output logic [CNT_W-1:0] crc_err_cnt,
    output logic             drop_sticky,
    output logic             halted,
    output logic             irq
`ifdef CR_XP10_DECOMP_BE_ERR_TRACE_EN
    ,
    output logic [TAG_W-1:0] last_err_tag,
    output logic [1:0]       last_err_type
`endif
);

    // FIFO word uses the be_err_stat_t field order {tag, size_err, crc_err}
    localparam int unsigned REC_W = TAG_W + 2;

    be_err_state_e    state_q;
    logic             halted_q;
    logic             fifo_empty, fifo_full;
    logic [REC_W-1:0] fifo_rdata;
    logic             accept, drop, pop, any_err;

    logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
    logic [CNT_W-1:0] size_err_cnt_q, size_err_cnt_d;
    logic [CNT_W-1:0] crc_err_cnt_q, crc_err_cnt_d;
    logic             drop_sticky_q, drop_sticky_d;
    logic             irq_q, irq_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1)) return v + 1'b1;
        return v;
    endfunction

    always_comb begin
        chk_ready = (state_q == BE_ERR_RUN) && !fifo_full;
        accept    = chk_done && chk_ready;
        drop      = chk_done && !chk_ready;
        any_err   = size_error || crc_error;
        pop       = stat_valid && stat_ready;
    end

    nx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_stat_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata ({chk_tag, size_error, crc_error}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        stat_valid    = !fifo_empty;
        stat_tag      = fifo_rdata[REC_W-1:2];
        stat_size_err = fifo_rdata[1];
        stat_crc_err  = fifo_rdata[0];
    end

    // Clear is applied first so a same-cycle increment lands on zero
    always_comb begin
        frm_cnt_d      = sat_inc(clr_cnt ? '0 : frm_cnt_q, accept);
        size_err_cnt_d = sat_inc(clr_cnt ? '0 : size_err_cnt_q, accept && size_error);
        crc_err_cnt_d  = sat_inc(clr_cnt ? '0 : crc_err_cnt_q, accept && crc_error);
        drop_sticky_d  = (drop_sticky_q && !clr_cnt) || drop;
        irq_d          = (irq_q && !irq_clr) || (accept && any_err) || drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_cnt_q      <= '0;
            size_err_cnt_q <= '0;
            crc_err_cnt_q  <= '0;
            drop_sticky_q  <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            frm_cnt_q      <= frm_cnt_d;
            size_err_cnt_q <= size_err_cnt_d;
            crc_err_cnt_q  <= crc_err_cnt_d;
            drop_sticky_q  <= drop_sticky_d;
            irq_q          <= irq_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BE_ERR_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                BE_ERR_RUN: begin
                    if (stop_on_err && accept && any_err) begin
                        state_q  <= BE_ERR_HALT;
                        halted_q <= 1'b1;
                    end
                end
                BE_ERR_HALT: begin
                    if (resume) begin
                        state_q  <= BE_ERR_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= BE_ERR_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        frm_cnt      = frm_cnt_q;
        size_err_cnt = size_err_cnt_q;
        crc_err_cnt  = crc_err_cnt_q;
        drop_sticky  = drop_sticky_q;
        halted       = halted_q;
        irq          = irq_q;
    end

`ifdef CR_XP10_DECOMP_BE_ERR_TRACE_EN
    logic [TAG_W-1:0] last_err_tag_q;
    logic [1:0]       last_err_type_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_err_tag_q  <= '0;
            last_err_type_q <= '0;
        end else if (accept && any_err) begin
            last_err_tag_q  <= chk_tag;
            last_err_type_q <= {size_error, crc_error};
        end
    end

    always_comb begin
        last_err_tag  = last_err_tag_q;
        last_err_type = last_err_type_q;
    end
`endif

endmodule

// File: doc/cr_xp10_decomp_be_err_stat.md
Name: cr_xp10_decomp_be_err_stat

Overview:
Downstream neighbour of the back-end frame checker. It consumes that stage's per-frame size_error and crc_error results and queues one status record per frame towards the back-end output/status path over a valid/ready handshake. It also keeps saturating frame and error statistics, raises a level interrupt, and can optionally halt intake on the first error.

Parameters:
DEPTH, 4, status FIFO depth in entries (power of 2, >=2)
TAG_W, 8, width of the frame tag carried with each check result
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, asynchronous, active-high
chk_done  in  1  one-cycle strobe; check result for one frame valid this cycle
chk_tag  in  TAG_W  frame tag, qualified by chk_done
size_error  in  1  frame size mismatch, qualified by chk_done
crc_error  in  1  CRC/Adler mismatch, qualified by chk_done
chk_ready  out  1  intake able to accept chk_done
stop_on_err  in  1  config: enter HALT on a recorded error
resume  in  1  pulse; leave HALT
clr_cnt  in  1  pulse; clear statistics counters
irq_clr  in  1  pulse; clear irq
stat_valid  out  1  status record available
stat_ready  in  1  downstream accepts record
stat_tag  out  TAG_W  record tag
stat_size_err  out  1  record size error
stat_crc_err  out  1  record CRC error
frm_cnt  out  CNT_W  frames recorded
size_err_cnt  out  CNT_W  frames with size_error
crc_err_cnt  out  CNT_W  frames with crc_error
drop_sticky  out  1  a chk_done was lost
halted  out  1  FSM in HALT
irq  out  1  level interrupt

Behaviour:
- Reset: all counters 0; stat_valid 0; drop_sticky 0; irq 0; halted 0; FSM RUN; FIFO empty; chk_ready 1 after reset is released.
- chk_ready = (state==RUN) && !fifo_full. This is a combinational function of registered state.
- Accept: chk_done && chk_ready pushes {chk_tag,size_error,crc_error}. The record is visible on stat_* the next cycle (1-cycle latency through an empty FIFO). No fall-through.
- Drop: chk_done && !chk_ready sets drop_sticky. Nothing is pushed, no counter changes, and the FSM does not move. drop_sticky clears only on reset or clr_cnt.
- Output: a record pops when stat_valid && stat_ready. stat_* hold stable while stat_valid && !stat_ready.
- Full FIFO with pop and chk_done in the same cycle: chk_ready is 0, so the input is dropped. Pop and push are never combined at full.
- Empty FIFO with push in the same cycle as stat_ready: no pop; the record appears the next cycle.
- Counters, updated on accept only, each saturating at 2^CNT_W-1:
  - frm_cnt +1 on every accept.
  - size_err_cnt +1 if size_error.
  - crc_err_cnt +1 if crc_error; both error counters may increment in the same cycle.
- clr_cnt in the same cycle as an increment: the counter becomes 1 (clear, then count).
- FSM states RUN and HALT:
  - RUN->HALT when stop_on_err && accept && (size_error||crc_error). The erroring record is still queued.
  - HALT->RUN on resume.
  - resume in RUN is ignored.
  - halted = (state==HALT).
  - The FIFO keeps draining in HALT.
- irq:
  - Set next cycle on any accepted record with an error, or on a new drop.
  - Cleared by irq_clr; set wins over a simultaneous clear.
- Asserting rst mid-operation discards queued records, counters and sticky state immediately.

Optional Feature:
Macro CR_XP10_DECOMP_BE_ERR_TRACE_EN.
- Defined: adds outputs last_err_tag (TAG_W) and last_err_type (2 bits: {size,crc}).
  - Both load on every accepted erroring record.
  - Both reset to 0; they are not cleared by clr_cnt.
- Undefined: the ports are absent and the logic is removed.

Decomposition:
- cr_xp10_decompPKG gets:
  - be_err_stat_t, a packed struct {tag[TAG_W], size_err, crc_err} used as the FIFO word;
  - the FSM enum be_err_state_e {BE_ERR_RUN, BE_ERR_HALT}.
- The status queue is an nx_fifo instance (DEPTH, WIDTH=$bits(be_err_stat_t)). This is the one natural sub-module.
- Counters, FSM and irq stay in the top module.

Test Plan:
- Clean frames: 3 accepts with no errors, stat_ready=1 -> 3 records out in order, frm_cnt=3, error counters 0, irq=0.
- Error mix: tag 0x11 size-only, 0x22 crc-only, 0x33 both -> size_err_cnt=2, crc_err_cnt=2, irq=1 from the first error; irq_clr clears it; irq_clr coincident with a new error keeps irq=1.
- Backpressure: stat_ready=0 with DEPTH+1 chk_done -> chk_ready=0 after DEPTH accepts, 5th dropped, drop_sticky=1, frm_cnt=4, records stable; draining returns tags in push order.
- Halt: stop_on_err=1, error on tag 0x40 -> halted=1 next cycle, chk_ready=0, record 0x40 delivered; the following chk_done is dropped; resume -> RUN, chk_ready=1.
- Saturation/clear: preload via 2^CNT_W accepts (CNT_W=4 build) -> frm_cnt stays 15; clr_cnt together with an accept -> frm_cnt=1.
- Reset mid-stream: rst with 2 queued records -> stat_valid=0, counters 0, FSM RUN; with the trace macro defined, last_err_tag=0.
